// File: rtl/ldst_mem_issuer_if.sv
// Request, memory and writeback signals between the load/store buffer, data memory
// and ROB writeback for ldst_mem_issuer.
interface ldst_mem_issuer_if #(parameter int ROBEN_W = 5);
   logic               in_valid;
   logic               in_ready;
   logic               in_is_store;
   logic [ROBEN_W-1:0] in_ROBEN;
   logic [31:0]        in_base;
   logic [31:0]        in_imm;
   logic [31:0]        in_data;

   logic               mem_Read_en;
   logic               mem_Write_en;
   logic [31:0]        mem_address;
   logic [31:0]        mem_data;
   logic [ROBEN_W-1:0] mem_ROBEN;
   logic [31:0]        mem_base;
   logic [31:0]        mem_imm;
   logic [ROBEN_W-1:0] MEMU_ROBEN;
   logic [31:0]        MEMU_Result;

   logic               out_valid;
   logic               out_ready;
   logic [ROBEN_W-1:0] out_ROBEN;
   logic [31:0]        out_result;
   logic               out_exception;

   modport slave (
      input  in_valid, in_is_store, in_ROBEN, in_base, in_imm, in_data,
      input  MEMU_ROBEN, MEMU_Result, out_ready,
      output in_ready,
      output mem_Read_en, mem_Write_en, mem_address, mem_data, mem_ROBEN, mem_base, mem_imm,
      output out_valid, out_ROBEN, out_result, out_exception
   );

   modport master (
      output in_valid, in_is_store, in_ROBEN, in_base, in_imm, in_data,
      output MEMU_ROBEN, MEMU_Result, out_ready,
      input  in_ready,
      input  mem_Read_en, mem_Write_en, mem_address, mem_data, mem_ROBEN, mem_base, mem_imm,
      input  out_valid, out_ROBEN, out_result, out_exception
   );
endinterface

// File: rtl/ldst_mem_issuer.sv
// In-order load/store issue queue: one memory access in flight, stores wait until
// they reach the ROB head, out-of-range addresses return an exception without a strobe.
module ldst_mem_issuer #(
   parameter int ROBEN_W  = 5,
   parameter int DEPTH    = 4,
   parameter int MEM_SIZE = 2048
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic [ROBEN_W-1:0] ROB_head_ROBEN,
   ldst_mem_issuer_if.slave   bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic               is_store;
      logic [ROBEN_W-1:0] roben;
      logic [31:0]        base;
      logic [31:0]        imm;
      logic [31:0]        data;
   } entry_t;

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   entry_t             q [DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [AW:0]        count;
   state_t             state, state_nxt;

   entry_t             head, in_entry;
   logic [31:0]        head_addr;
   logic               empty, full, head_oor, eligible, push, pop, out_fire;

   logic               rd_en, wr_en;
   logic [31:0]        m_addr, m_data, m_base, m_imm;
   logic [ROBEN_W-1:0] m_roben;
   logic               o_valid, o_exc;
   logic [ROBEN_W-1:0] o_roben;
   logic [31:0]        o_result;

   assign head      = q[rd_ptr];
   assign head_addr = head.base + head.imm;
   assign head_oor  = head_addr > 32'(MEM_SIZE - 1);
   assign empty     = (count == '0);
   assign full      = (count == (AW+1)'(DEPTH));
   assign eligible  = !empty && (!head.is_store || (ROB_head_ROBEN == head.roben));
   assign out_fire  = o_valid && bus.out_ready;
   // in_ready looks only at the registered count, so a same-cycle pop never makes room
   assign push      = bus.in_valid && !full && !flush;

   assign in_entry = '{is_store: bus.in_is_store, roben: bus.in_ROBEN,
                       base: bus.in_base, imm: bus.in_imm, data: bus.in_data};

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: if (eligible) begin
            pop       = 1'b1;
            state_nxt = head_oor ? RESP : REQ;
         end
         REQ:  state_nxt = RESP;
         RESP: if (out_fire) begin
            if (eligible) begin
               pop       = 1'b1;
               state_nxt = head_oor ? RESP : REQ;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (flush) begin
         pop       = 1'b0;
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (push) q[wr_ptr] <= in_entry;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_en    <= 1'b0;
         wr_en    <= 1'b0;
         m_addr   <= '0;
         m_data   <= '0;
         m_roben  <= '0;
         m_base   <= '0;
         m_imm    <= '0;
         o_valid  <= 1'b0;
         o_roben  <= '0;
         o_result <= '0;
         o_exc    <= 1'b0;
      end else if (flush) begin
         rd_en   <= 1'b0;
         wr_en   <= 1'b0;
         o_valid <= 1'b0;
      end else if (pop && !head_oor) begin
         rd_en   <= !head.is_store;
         wr_en   <= head.is_store;
         m_addr  <= head_addr;
         m_data  <= head.data;
         m_roben <= head.roben;
         m_base  <= head.base;
         m_imm   <= head.imm;
         o_valid <= 1'b0;
      end else if (pop) begin
         o_valid  <= 1'b1;
         o_exc    <= 1'b1;
         o_result <= '0;
         o_roben  <= head.roben;
      end else if (state == REQ) begin
         // wr_en still marks the access kind for the whole REQ cycle
         rd_en    <= 1'b0;
         wr_en    <= 1'b0;
         o_roben  <= bus.MEMU_ROBEN;
         o_result <= wr_en ? 32'd0 : bus.MEMU_Result;
         o_exc    <= 1'b0;
         o_valid  <= 1'b1;
      end else if (out_fire) begin
         o_valid <= 1'b0;
      end
   end

   assign bus.in_ready      = !full;
   assign bus.mem_Read_en   = rd_en;
   assign bus.mem_Write_en  = wr_en;
   assign bus.mem_address   = m_addr;
   assign bus.mem_data      = m_data;
   assign bus.mem_ROBEN     = m_roben;
   assign bus.mem_base      = m_base;
   assign bus.mem_imm       = m_imm;
   assign bus.out_valid     = o_valid;
   assign bus.out_ROBEN     = o_roben;
   assign bus.out_result    = o_result;
   assign bus.out_exception = o_exc;
endmodule

// File: tb/tb_ldst_mem_issuer.sv
// Directed bench for ldst_mem_issuer: vector table for single accesses, hand-written
// sequences for queue fill/drain, flush and asynchronous reset.
module tb_ldst_mem_issuer;
   logic       clk;
   logic       rst;
   logic       flush;
   logic [4:0] rob_head;
   int         n_cmp = 0;
   int         n_bad = 0;

   ldst_mem_issuer_if #(.ROBEN_W(5)) bus();

   ldst_mem_issuer #(.ROBEN_W(5), .DEPTH(4), .MEM_SIZE(2048)) dut (
      .clk(clk), .rst(rst), .flush(flush), .ROB_head_ROBEN(rob_head), .bus(bus.slave)
   );

   // data memory: word 15 holds 0x1234, every other word returns A5A5 over its address
   assign bus.MEMU_ROBEN  = bus.mem_ROBEN;
   assign bus.MEMU_Result = (bus.mem_address == 32'd15) ? 32'h1234 : {16'hA5A5, bus.mem_address[15:0]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic v; logic st; logic [4:0] tag; logic [31:0] base, imm, data; logic [4:0] head; logic ordy;
      logic e_rdy, e_rd, e_wr; logic [31:0] e_addr, e_mdat; logic e_ov; logic [4:0] e_tag;
      logic [31:0] e_res; logic e_exc;
   } vec_t;

   vec_t vt[20];

   function automatic vec_t mk(logic v, logic st, logic [4:0] tag, logic [31:0] base, logic [31:0] imm,
                               logic [31:0] data, logic [4:0] head, logic e_rd, logic e_wr,
                               logic [31:0] e_addr, logic [31:0] e_mdat, logic e_ov, logic [4:0] e_tag,
                               logic [31:0] e_res, logic e_exc);
      vec_t r;
      r.v = v; r.st = st; r.tag = tag; r.base = base; r.imm = imm; r.data = data; r.head = head;
      r.ordy = 1'b1; r.e_rdy = 1'b1; r.e_rd = e_rd; r.e_wr = e_wr; r.e_addr = e_addr; r.e_mdat = e_mdat;
      r.e_ov = e_ov; r.e_tag = e_tag; r.e_res = e_res; r.e_exc = e_exc;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_push(input logic st, input logic [4:0] tag, input logic [31:0] base,
                             input logic [31:0] imm, input logic [31:0] data);
      bus.in_valid = 1'b1; bus.in_is_store = st; bus.in_ROBEN = tag;
      bus.in_base = base; bus.in_imm = imm; bus.in_data = data;
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      chk({nm, "_rd"},       32'(bus.mem_Read_en), 32'd0);
      chk({nm, "_wr"},       32'(bus.mem_Write_en), 32'd0);
      chk({nm, "_addr"},     bus.mem_address, 32'd0);
      chk({nm, "_mdata"},    bus.mem_data, 32'd0);
      chk({nm, "_mtag"},     32'(bus.mem_ROBEN), 32'd0);
      chk({nm, "_mbase"},    bus.mem_base, 32'd0);
      chk({nm, "_mimm"},     bus.mem_imm, 32'd0);
      chk({nm, "_ov"},       32'(bus.out_valid), 32'd0);
      chk({nm, "_otag"},     32'(bus.out_ROBEN), 32'd0);
      chk({nm, "_ores"},     bus.out_result, 32'd0);
      chk({nm, "_oexc"},     32'(bus.out_exception), 32'd0);
   endtask

   // push an out-of-range load and wait for it to sit in RESP with out_ready low
   task automatic park_resp(input logic [4:0] tag);
      bus.out_ready = 1'b0;
      drive_push(1'b0, tag, 32'd4000, 32'd0, 32'd0);
      step();
      bus.in_valid = 1'b0;
      step();
      chk("park_ov", 32'(bus.out_valid), 32'd1);
      chk("park_exc", 32'(bus.out_exception), 32'd1);
      chk("park_tag", 32'(bus.out_ROBEN), 32'(tag));
   endtask

   initial begin
      logic [4:0] exp_tags[6];
      int got, last_c;
      logic acc;

      rst = 1'b0; flush = 1'b0; rob_head = 5'd31;
      bus.in_valid = 1'b0; bus.in_is_store = 1'b0; bus.in_ROBEN = '0;
      bus.in_base = '0; bus.in_imm = '0; bus.in_data = '0; bus.out_ready = 1'b1;
      #3;
      check_reset_vals("rst0");
      step(); step();
      rst = 1'b1;
      step();

      //          v  st tag base          imm    data   head rd wr addr   mdat  ov tag res            exc
      vt[0]  = mk(1, 0, 3,  32'd10,       32'd5, 0,     31,  0, 0, 0,     0,    0, 0, 0,             0);
      vt[1]  = mk(0, 0, 0,  0,            0,     0,     31,  1, 0, 15,    0,    0, 0, 0,             0);
      vt[2]  = mk(0, 0, 0,  0,            0,     0,     31,  0, 0, 0,     0,    1, 3, 32'h1234,      0);
      vt[3]  = mk(0, 0, 0,  0,            0,     0,     31,  0, 0, 0,     0,    0, 0, 0,             0);
      vt[4]  = mk(1, 1, 6,  32'd90,       32'd10, 32'hAB, 2, 0, 0, 0,     0,    0, 0, 0,             0);
      vt[5]  = mk(0, 0, 0,  0,            0,     0,     2,   0, 0, 0,     0,    0, 0, 0,             0);
      vt[6]  = mk(0, 0, 0,  0,            0,     0,     6,   0, 1, 100,   32'hAB, 0, 0, 0,           0);
      vt[7]  = mk(0, 0, 0,  0,            0,     0,     6,   0, 0, 0,     0,    1, 6, 0,             0);
      vt[8]  = mk(0, 0, 0,  0,            0,     0,     31,  0, 0, 0,     0,    0, 0, 0,             0);
      vt[9]  = mk(1, 0, 9,  32'd2040,     32'd8, 0,     31,  0, 0, 0,     0,    0, 0, 0,             0);
      vt[10] = mk(0, 0, 0,  0,            0,     0,     31,  0, 0, 0,     0,    1, 9, 0,             1);
      vt[11] = mk(0, 0, 0,  0,            0,     0,     31,  0, 0, 0,     0,    0, 0, 0,             0);
      vt[12] = mk(1, 0, 4,  32'd2047,     32'd0, 0,     31,  0, 0, 0,     0,    0, 0, 0,             0);
      vt[13] = mk(0, 0, 0,  0,            0,     0,     31,  1, 0, 2047,  0,    0, 0, 0,             0);
      vt[14] = mk(0, 0, 0,  0,            0,     0,     31,  0, 0, 0,     0,    1, 4, 32'hA5A507FF,  0);
      vt[15] = mk(0, 0, 0,  0,            0,     0,     31,  0, 0, 0,     0,    0, 0, 0,             0);
      vt[16] = mk(1, 0, 1,  32'hFFFFFFFF, 32'd2, 0,     31,  0, 0, 0,     0,    0, 0, 0,             0);
      vt[17] = mk(0, 0, 0,  0,            0,     0,     31,  1, 0, 1,     0,    0, 0, 0,             0);
      vt[18] = mk(0, 0, 0,  0,            0,     0,     31,  0, 0, 0,     0,    1, 1, 32'hA5A50001,  0);
      vt[19] = mk(0, 0, 0,  0,            0,     0,     31,  0, 0, 0,     0,    0, 0, 0,             0);

      for (int i = 0; i < 20; i++) begin
         bus.in_valid = vt[i].v; bus.in_is_store = vt[i].st; bus.in_ROBEN = vt[i].tag;
         bus.in_base = vt[i].base; bus.in_imm = vt[i].imm; bus.in_data = vt[i].data;
         rob_head = vt[i].head; bus.out_ready = vt[i].ordy;
         step();
         chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vt[i].e_rdy));
         chk($sformatf("v%0d_rd", i), 32'(bus.mem_Read_en), 32'(vt[i].e_rd));
         chk($sformatf("v%0d_wr", i), 32'(bus.mem_Write_en), 32'(vt[i].e_wr));
         chk($sformatf("v%0d_ov", i), 32'(bus.out_valid), 32'(vt[i].e_ov));
         if (vt[i].e_rd || vt[i].e_wr)
            chk($sformatf("v%0d_addr", i), bus.mem_address, vt[i].e_addr);
         if (vt[i].e_wr)
            chk($sformatf("v%0d_mdata", i), bus.mem_data, vt[i].e_mdat);
         if (vt[i].e_ov) begin
            chk($sformatf("v%0d_otag", i), 32'(bus.out_ROBEN), 32'(vt[i].e_tag));
            chk($sformatf("v%0d_ores", i), bus.out_result, vt[i].e_res);
            chk($sformatf("v%0d_oexc", i), 32'(bus.out_exception), 32'(vt[i].e_exc));
         end
      end
      bus.in_valid = 1'b0; rob_head = 5'd31;

      // fill with the pipeline stalled, then drain in order
      park_resp(5'd20);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("fill%0d_rdy", i), 32'(bus.in_ready), 32'd1);
         drive_push(1'b0, 5'(10 + i), 32'd0, 32'(20 + i), 32'd0);
         step();
      end
      bus.in_valid = 1'b0;
      chk("full_rdy", 32'(bus.in_ready), 32'd0);
      step();
      chk("full_hold_ov", 32'(bus.out_valid), 32'd1);
      drive_push(1'b0, 5'd14, 32'd0, 32'd24, 32'd0);
      bus.out_ready = 1'b1;
      exp_tags = '{5'd20, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
      got = 0; last_c = 0;
      for (int c = 0; c < 60 && got < 6; c++) begin
         if (bus.out_valid) begin
            chk($sformatf("drain%0d_tag", got), 32'(bus.out_ROBEN), 32'(exp_tags[got]));
            chk($sformatf("drain%0d_res", got), bus.out_result,
                (got == 0) ? 32'd0 : {16'hA5A5, 16'(20 + got - 1)});
            chk($sformatf("drain%0d_exc", got), 32'(bus.out_exception), (got == 0) ? 32'd1 : 32'd0);
            if (got > 0) chk($sformatf("drain%0d_gap", got), 32'(c - last_c), 32'd2);
            last_c = c;
            got++;
         end
         acc = bus.in_valid && bus.in_ready;
         step();
         if (acc) bus.in_valid = 1'b0;
      end
      chk("drain_count", 32'(got), 32'd6);
      bus.in_valid = 1'b0;
      step();

      // flush while a load is in REQ with three entries behind it
      park_resp(5'd21);
      for (int i = 0; i < 4; i++) begin
         drive_push(1'b0, 5'(1 + i), 32'd0, 32'(40 + i), 32'd0);
         step();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      step();
      chk("fl_req_rd", 32'(bus.mem_Read_en), 32'd1);
      chk("fl_req_addr", bus.mem_address, 32'd40);
      flush = 1'b1;
      drive_push(1'b0, 5'd7, 32'd0, 32'd50, 32'd0);
      step();
      flush = 1'b0; bus.in_valid = 1'b0;
      chk("fl_in_ready", 32'(bus.in_ready), 32'd1);
      chk("fl_ov", 32'(bus.out_valid), 32'd0);
      chk("fl_rd", 32'(bus.mem_Read_en), 32'd0);
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("fl_quiet%0d_ov", i), 32'(bus.out_valid), 32'd0);
         chk($sformatf("fl_quiet%0d_rd", i), 32'(bus.mem_Read_en), 32'd0);
      end

      // asynchronous reset during RESP
      bus.out_ready = 1'b0;
      drive_push(1'b0, 5'd8, 32'd30, 32'd0, 32'd0);
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      chk("rr_ov", 32'(bus.out_valid), 32'd1);
      chk("rr_tag", 32'(bus.out_ROBEN), 32'd8);
      chk("rr_addr", bus.mem_address, 32'd30);
      #2;
      rst = 1'b0;
      #1;
      check_reset_vals("rr_async");
      step();
      rst = 1'b1;
      bus.out_ready = 1'b1;
      step(); step();
      chk("rr_after_ov", 32'(bus.out_valid), 32'd0);
      chk("rr_after_rd", 32'(bus.mem_Read_en), 32'd0);
      drive_push(1'b0, 5'd5, 32'd10, 32'd5, 32'd0);
      step();
      bus.in_valid = 1'b0;
      step();
      chk("rr_new_rd", 32'(bus.mem_Read_en), 32'd1);
      chk("rr_new_addr", bus.mem_address, 32'd15);
      step();
      chk("rr_new_ov", 32'(bus.out_valid), 32'd1);
      chk("rr_new_tag", 32'(bus.out_ROBEN), 32'd5);
      chk("rr_new_res", bus.out_result, 32'h1234);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ldst_mem_issuer.md
LDST_MEM_ISSUER -- requirements
Module: ldst_mem_issuer

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- ROBEN_W, 5, ROB entry tag width.
- DEPTH, 4, request queue entries (power of 2).
- MEM_SIZE, 2048, data-memory words; the valid address range is 0..MEM_SIZE-1.

REQ-002 The block SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  the only clock; all state SHALL update on posedge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash.
- in_valid  in  1  load/store-buffer request valid.
- in_ready  out  1  queue can accept.
- in_is_store  in  1  1=store, 0=load.
- in_ROBEN  in  ROBEN_W  tag.
- in_base  in  32  base register value.
- in_imm  in  32  immediate.
- in_data  in  32  store data.
- ROB_head_ROBEN  in  ROBEN_W  current ROB head tag.
- mem_Read_en  out  1  memory read strobe.
- mem_Write_en  out  1  memory write strobe.
- mem_address  out  32  word address.
- mem_data  out  32  write data.
- mem_ROBEN  out  ROBEN_W  tag to memory.
- mem_base  out  32  base value forwarded to memory.
- mem_imm  out  32  immediate forwarded to memory.
- MEMU_ROBEN  in  ROBEN_W  tag returned by memory.
- MEMU_Result  in  32  read data returned by memory.
- out_valid  out  1  writeback valid.
- out_ready  in  1  writeback consumer accepts.
- out_ROBEN  out  ROBEN_W  writeback tag.
- out_result  out  32  load data; 0 for stores.
- out_exception  out  1  out-of-range address.

Function
REQ-003 The queue SHALL be an in-order FIFO of DEPTH entries.
- in_ready = not full.
- A push SHALL occur on in_valid && in_ready.
- A pop in the same cycle SHALL NOT free space for a push in that cycle.

REQ-004 The head address SHALL be base+imm as a 32-bit unsigned sum, discarding carry. The entry is out of range when the sum > MEM_SIZE-1.

REQ-005 The head SHALL be eligible when the queue is non-empty and either of the following holds:
- it is a load;
- it is a store and ROB_head_ROBEN equals its tag.

REQ-006 The FSM SHALL have three states: IDLE, REQ and RESP.

REQ-007 From IDLE, or from RESP when the output handshake completes in the same cycle, an eligible head SHALL be popped as follows:
- In range: go to REQ and register mem_Read_en=!is_store, mem_Write_en=is_store, mem_address, mem_data, mem_ROBEN, mem_base and mem_imm.
- Out of range: go directly to RESP with out_exception=1, out_result=0 and out_ROBEN=the entry tag. No memory strobe SHALL be asserted.

REQ-008 REQ SHALL last exactly one cycle. At the next posedge the block SHALL do all of the following:
- capture out_ROBEN=MEMU_ROBEN;
- capture out_result=MEMU_Result for loads, or 0 for stores;
- set out_exception=0 and out_valid=1;
- deassert both strobes;
- enter RESP.

REQ-009 In RESP, out_valid SHALL hold, and out_ROBEN, out_result and out_exception SHALL remain stable until out_valid && out_ready. On that handshake the block SHALL enter IDLE, or REQ/RESP per REQ-007.

REQ-010 At most one request SHALL be in flight. Strobes SHALL never be high outside REQ, and mem_Read_en and mem_Write_en SHALL never be high together.

REQ-011 Back-to-back throughput SHALL be one access per 2 cycles when out_ready=1.

REQ-012 flush SHALL have highest priority. At the next posedge the block SHALL:
- empty the queue;
- clear out_valid;
- deassert the strobes;
- enter IDLE.
A store already strobed in REQ is not recalled, and its response SHALL be discarded. A push in the flush cycle SHALL be dropped.

Reset
REQ-013 While rst=0 the block SHALL hold the following values:
- queue empty, in_ready=1, state IDLE;
- mem_Read_en=0, mem_Write_en=0;
- mem_address, mem_data, mem_ROBEN, mem_base and mem_imm all 0;
- out_valid=0, out_ROBEN=0, out_result=0, out_exception=0.

REQ-014 A reset asserted mid-REQ or mid-RESP SHALL abandon the operation with no later response.

Verification
REQ-015 The bench SHALL cover the following directed scenarios:
- Load base=10, imm=5, tag 3, memory word 15=0x1234, out_ready=1 -> one-cycle mem_Read_en with address 15; next cycle out_valid, out_ROBEN=3, out_result=0x1234.
- Store tag 6, sum=100, data=0xAB, ROB_head_ROBEN=2 -> no strobe. When ROB_head_ROBEN becomes 6 -> one-cycle mem_Write_en with address 100; response has out_result=0 and out_exception=0.
- Load base=2040, imm=8 (sum 2048) -> no strobe; out_valid with out_exception=1 in the cycle after the pop.
- Push 5 loads with out_ready=0 -> in_ready falls after 4 pushes. Raise out_ready -> results are delivered in order, one per 2 cycles, with no loss.
- Assert flush while in REQ with 3 entries queued -> the next cycle has an empty queue, out_valid=0 and state IDLE; no later writeback occurs.
- Pull rst low during RESP -> all outputs go to the REQ-013 values immediately; after release, a new load completes normally.
